multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_pkg.sv | 46 ++++
 rtl/multicycle_outdec.sv | 95 +++++++++
 rtl/multicycle_ctrl.sv | 91 +++++++++
 tb/tb_multicycle_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes and datapath selects.
// The optional BNE state and opcode exist only when MULTICYCLE_BNE_EN is defined.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
`ifdef MULTICYCLE_BNE_EN
        , S_BNE  = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_outdec.sv
// Moore output decoder for the multicycle controller; only fetch handshakes and
// branch resolution look at inputs. BNE decoding is present with MULTICYCLE_BNE_EN.
module multicycle_outdec
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop
);

    logic pcwrite;
    logic branch;
    logic branch_n;

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        branch_n = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        alusrca  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrcb  = SRCB_REG;
        pcsrc    = PC_ALU;
        aluop    = ALUOP_ADD;
        case (state_t'(state))
            // Instruction register and PC only move once memory delivers the word
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: alusrcb = SRCB_BROFF;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQ: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PC_BRANCH;
                branch  = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = PC_JUMP;
                pcwrite = 1'b1;
            end
`ifdef MULTICYCLE_BNE_EN
            S_BNE: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = PC_BRANCH;
                branch_n = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // zero feeds pcen directly so a branch resolves in the same cycle
    assign pcen = pcwrite | (branch & zero) | (branch_n & ~zero);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: state register and next-state logic; outputs come from
// multicycle_outdec. Define MULTICYCLE_BNE_EN to add the BNE instruction.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcen,
    output logic               irwrite,
    output logic               regwrite,
    output logic               memwrite,
    output logic               iord,
    output logic               alusrca,
    output logic               regdst,
    output logic               memtoreg,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [1:0]         aluop,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_t cur;
    state_t nxt;
    logic   bad_op;
    logic   ready_gated;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt    = cur;
        bad_op = 1'b0;
        case (cur)
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       nxt = S_BNE;
`endif
                    default: begin
                        bad_op = 1'b1;
                        nxt    = S_FETCH;
                    end
                endcase
            end
            // The instruction register holds the opcode stable through the instruction
            S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWR:  if (mem_ready) nxt = S_FETCH;
            S_EXEC:   nxt = S_ALUWB;
            S_ADDIEX: nxt = S_ADDIWB;
            default:  nxt = S_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH; masking mem_ready keeps FETCH's strobes quiet too
    assign ready_gated = mem_ready & ~reset;
    assign illegal     = bad_op;
    assign state       = STATE_W'(cur);

    multicycle_outdec u_outdec (
        .state     (cur),
        .mem_ready (ready_gated),
        .zero      (zero),
        .pcen      (pcen),
        .irwrite   (irwrite),
        .regwrite  (regwrite),
        .memwrite  (memwrite),
        .iord      (iord),
        .alusrca   (alusrca),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .aluop     (aluop)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: instruction table, hand-written corner sequences and a
// randomized run against an instruction-level reference model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg;
    logic [1:0]  alusrcb, pcsrc, aluop;
    logic        illegal;
    logic [3:0]  state;
    logic [14:0] outs;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .iord(iord), .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal), .state(state)
    );

    assign outs = {pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg,
                   alusrcb, pcsrc, aluop, illegal};

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Reference model: each instruction is a list of states visited after DECODE
    int route[$];
    int m_cur;

    function automatic void load_route(logic [5:0] op);
        route.delete();
        case (op)
            6'b100011: route = '{2, 3, 4};
            6'b101011: route = '{2, 5};
            6'b000000: route = '{6, 7};
            6'b001000: route = '{9, 10};
            6'b000100: route = '{8};
            6'b000010: route = '{11};
`ifdef MULTICYCLE_BNE_EN
            6'b000101: route = '{12};
`endif
            default: ;
        endcase
    endfunction

    function automatic void model_step(logic mr);
        if (m_cur == 0)                           m_cur = mr ? 1 : 0;
        else if ((m_cur == 3 || m_cur == 5) && !mr) m_cur = m_cur;
        else if (route.size() > 0)                m_cur = route.pop_front();
        else                                      m_cur = 0;
    endfunction

    function automatic logic [14:0] exp_outs(int s, logic mr, logic z, logic ill);
        logic pw, br, ir, rw, mw, io, sa, rd, mt;
        logic [1:0] sb, ps, ao;
        {pw, br, ir, rw, mw, io, sa, rd, mt} = '0;
        sb = 2'b00; ps = 2'b00; ao = 2'b00;
        case (s)
            0:     begin sb = 2'b01; ir = mr; pw = mr; end
            1:     sb = 2'b11;
            2, 9:  begin sa = 1'b1; sb = 2'b10; end
            3:     io = 1'b1;
            4:     begin rw = 1'b1; mt = 1'b1; end
            5:     begin io = 1'b1; mw = 1'b1; end
            6:     begin sa = 1'b1; ao = 2'b10; end
            7:     begin rw = 1'b1; rd = 1'b1; end
            8:     begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = z; end
            10:    rw = 1'b1;
            11:    begin ps = 2'b10; pw = 1'b1; end
            12:    begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = !z; end
            default: ;
        endcase
        return {pw | br, ir, rw, mw, io, sa, rd, mt, sb, ps, ao, ill};
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] r;
        case ($urandom_range(0, 7))
            0: r = 6'b100011;
            1: r = 6'b101011;
            2: r = 6'b000000;
            3: r = 6'b001000;
            4: r = 6'b000100;
            5: r = 6'b000010;
            6: r = 6'b000101;
            default: r = 6'($urandom);
        endcase
        return r;
    endfunction

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         cycles;
        int         ill_n;
        int         pcen_n;
        int         rw_n;
        int         mw_n;
    } vec_t;

    vec_t vt[10];
    int   lw_seq[6];
    int   cyc, ic, pc, rc, mc, mw_cnt;
    logic ill;

    initial begin
        vt[0] = '{6'b100011, 1'b0, 5, 0, 1, 1, 0};
        vt[1] = '{6'b101011, 1'b0, 4, 0, 1, 0, 1};
        vt[2] = '{6'b000000, 1'b0, 4, 0, 1, 1, 0};
        vt[3] = '{6'b001000, 1'b0, 4, 0, 1, 1, 0};
        vt[4] = '{6'b000100, 1'b1, 3, 0, 2, 0, 0};
        vt[5] = '{6'b000100, 1'b0, 3, 0, 1, 0, 0};
        vt[6] = '{6'b000010, 1'b0, 3, 0, 2, 0, 0};
        vt[7] = '{6'b111111, 1'b0, 2, 1, 1, 0, 0};
`ifdef MULTICYCLE_BNE_EN
        vt[8] = '{6'b000101, 1'b0, 3, 0, 2, 0, 0};
        vt[9] = '{6'b000101, 1'b1, 3, 0, 1, 0, 0};
`else
        vt[8] = '{6'b000101, 1'b0, 2, 1, 1, 0, 0};
        vt[9] = '{6'b000101, 1'b1, 2, 1, 1, 0, 0};
`endif
        lw_seq = '{0, 1, 2, 3, 4, 0};

        // Reset state, with mem_ready high so FETCH's strobes would show if not masked
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = 6'b100011;
        #2;
        chk("reset_state", int'(state), 0);
        chk("reset_strobes", int'({irwrite, pcen, regwrite, memwrite}), 0);

        // lw with memory always ready; first edge after reset leaves FETCH
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #2;
            chk("lw_state", int'(state), lw_seq[i]);
            chk("lw_regwrite", int'(regwrite), int'(lw_seq[i] == 4));
            chk("lw_memtoreg", int'(memtoreg), int'(lw_seq[i] == 4));
            tick();
        end

        // sw with two wait cycles in MEMWR
        do_reset();
        opcode = 6'b101011; mem_ready = 1'b1;
        repeat (3) tick();
        #2;
        chk("sw_at_memwr", int'(state), 5);
        mw_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            mem_ready = (k >= 2);
            #2;
            if (memwrite) mw_cnt++;
            tick();
            if (state == 4'd0) break;
        end
        chk("sw_memwrite_cycles", mw_cnt, 3);
        chk("sw_end_state", int'(state), 0);

        // beq: pcen follows zero combinationally in BEQ only
        do_reset();
        opcode = 6'b000100; mem_ready = 1'b1;
        tick();
        zero = 1'b1;
        #2;
        chk("beq_decode_pcen", int'(pcen), 0);
        tick();
        #2;
        chk("beq_state", int'(state), 8);
        chk("beq_taken_pcen", int'(pcen), 1);
        chk("beq_pcsrc", int'(pcsrc), 1);
        zero = 1'b0;
        #1;
        chk("beq_not_taken_pcen", int'(pcen), 0);
        tick();
        chk("beq_next", int'(state), 0);

        // Unsupported opcode
        do_reset();
        opcode = 6'b111111; mem_ready = 1'b1;
        tick();
        #2;
        chk("ill_pulse", int'(illegal), 1);
        chk("ill_strobes", int'({regwrite, memwrite, irwrite, pcen}), 0);
        tick();
        chk("ill_next", int'(state), 0);
        chk("ill_clear", int'(illegal), 0);

        // Asynchronous reset while MEMRD waits on memory
        do_reset();
        opcode = 6'b100011; mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        #2;
        chk("rdwait_state", int'(state), 3);
        mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_strobes", int'({irwrite, pcen, regwrite, memwrite, iord}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        chk("post_rst_state", int'(state), 0);
        tick();
        chk("post_rst_first_edge", int'(state), 1);

        // bne with zero=0
        do_reset();
        opcode = 6'b000101; mem_ready = 1'b1; zero = 1'b0;
        tick();
        #2;
`ifdef MULTICYCLE_BNE_EN
        chk("bne_legal", int'(illegal), 0);
        tick();
        chk("bne_state", int'(state), 12);
        chk("bne_taken_pcen", int'(pcen), 1);
        chk("bne_pcsrc", int'(pcsrc), 1);
        zero = 1'b1;
        #1;
        chk("bne_not_taken_pcen", int'(pcen), 0);
`else
        chk("bne_illegal", int'(illegal), 1);
        tick();
        chk("bne_next", int'(state), 0);
`endif

        // Instruction table: cycle counts and strobe totals with memory always ready
        for (int v = 0; v < 10; v++) begin
            do_reset();
            opcode = vt[v].op; zero = vt[v].z; mem_ready = 1'b1;
            cyc = 0; ic = 0; pc = 0; rc = 0; mc = 0;
            for (int k = 0; k < 20; k++) begin
                #2;
                cyc++;
                ic += int'(illegal);
                pc += int'(pcen);
                rc += int'(regwrite);
                mc += int'(memwrite);
                tick();
                if (state == 4'd0) break;
            end
            chk($sformatf("vec%0d_cycles", v), cyc, vt[v].cycles);
            chk($sformatf("vec%0d_illegal", v), ic, vt[v].ill_n);
            chk($sformatf("vec%0d_pcen", v), pc, vt[v].pcen_n);
            chk($sformatf("vec%0d_regwrite", v), rc, vt[v].rw_n);
            chk($sformatf("vec%0d_memwrite", v), mc, vt[v].mw_n);
        end

        // Randomized run against the reference model
        do_reset();
        m_cur = 0;
        route.delete();
        for (int c = 0; c < 1500; c++) begin
            if (m_cur == 0) opcode = pick_op();
            mem_ready = ($urandom_range(0, 3) != 0);
            zero      = 1'($urandom_range(0, 1));
            #2;
            ill = 1'b0;
            if (m_cur == 1) begin
                load_route(opcode);
                ill = (route.size() == 0);
            end
            chk("rnd_state", int'(state), m_cur);
            chk("rnd_outs", int'(outs), int'(exp_outs(m_cur, mem_ready, zero, ill)));
            model_step(mem_ready);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
